// File: rtl/me_job_sched.sv
// Round-robin job sequencer sharing one modular-exponentiation engine
// between two requesters: grant, start, stream operands, collect results.
module me_job_sched #(
    parameter int K         = 128,
    parameter int N         = 32,
    parameter int START_GAP = 10,
    parameter int TIMEOUT   = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req,
    output logic [1:0]           gnt,
    output logic                 op_rd_en,
    output logic [$clog2(N)-1:0] op_rd_idx,
    input  logic [K-1:0]         op_x,
    input  logic [K-1:0]         op_y,
    output logic                 me_start,
    output logic [K-1:0]         me_x,
    output logic                 me_x_valid,
    output logic [K-1:0]         me_y,
    output logic                 me_y_valid,
    input  logic [K-1:0]         me_result,
    input  logic                 me_valid,
    output logic [K-1:0]         res_data,
    output logic                 res_valid,
    output logic [$clog2(N)-1:0] res_idx,
    output logic                 res_sel,
    output logic                 job_done,
    output logic                 job_err
);

    localparam int IW   = $clog2(N);
    localparam int CW_T = $clog2(TIMEOUT + 1);
    localparam int CW_S = $clog2(N + 2);
    localparam int CW_G = $clog2(START_GAP + 1);
    localparam int CW_A = (CW_T > CW_S) ? CW_T : CW_S;
    localparam int CW   = (CW_A > CW_G) ? CW_A : CW_G;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_GAP,
        S_STREAM,
        S_WAIT,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          sel_q, sel_d;
    logic          rr_q, rr_d;
    logic          err_q, err_d;
    logic          rd_q, rd_d;
    logic          xv_q, xv_d;
    logic [K-1:0]  mx_q, mx_d;
    logic [K-1:0]  my_q, my_d;
    logic          rv_q, rv_d;
    logic [K-1:0]  rdat_q, rdat_d;
    logic [IW-1:0] ridx_q, ridx_d;

    logic          rd_now;
    logic          pad_now;

    assign rd_now  = (state_q == S_STREAM) && (cnt_q < CW'(N));
    assign pad_now = (state_q == S_STREAM) && (cnt_q == CW'(N + 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        err_d   = err_q;
        rv_d    = 1'b0;
        rdat_d  = rdat_q;
        ridx_d  = ridx_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    sel_d   = (req[0] && req[1]) ? rr_q : req[1];
                    gnt_d   = sel_d ? 2'b10 : 2'b01;
                    rr_d    = ~sel_d;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = (START_GAP == 0) ? S_STREAM : S_GAP;
            end
            S_GAP: begin
                if (cnt_q == CW'(START_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = S_STREAM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STREAM: begin
                // N reads, N in-flight words, then one zero pad word
                if (pad_now) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (me_valid) begin
                    rv_d    = 1'b1;
                    rdat_d  = me_result;
                    ridx_d  = '0;
                    cnt_d   = CW'(1);
                    state_d = (N == 1) ? S_DONE : S_COLLECT;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_COLLECT: begin
                if (me_valid) begin
                    rv_d   = 1'b1;
                    rdat_d = me_result;
                    ridx_d = IW'(cnt_q);
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = S_DONE;
                    end
                end else begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_d = rd_now;
        xv_d = rd_q | pad_now;
        mx_d = rd_q ? op_x : '0;
        my_d = rd_q ? op_y : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            gnt_q   <= 2'b00;
            sel_q   <= 1'b0;
            rr_q    <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            xv_q    <= 1'b0;
            mx_q    <= '0;
            my_q    <= '0;
            rv_q    <= 1'b0;
            rdat_q  <= '0;
            ridx_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            xv_q    <= xv_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            rv_q    <= rv_d;
            rdat_q  <= rdat_d;
            ridx_q  <= ridx_d;
        end
    end

    assign gnt        = gnt_q;
    assign op_rd_en   = rd_now;
    assign op_rd_idx  = rd_now ? IW'(cnt_q) : '0;
    assign me_start   = (state_q == S_START);
    assign me_x       = mx_q;
    assign me_y       = my_q;
    assign me_x_valid = xv_q;
    assign me_y_valid = xv_q;
    assign res_data   = rdat_q;
    assign res_valid  = rv_q;
    assign res_idx    = ridx_q;
    assign res_sel    = sel_q;
    assign job_done   = (state_q == S_DONE);
    assign job_err    = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_me_job_sched.sv
// Scoreboard bench for me_job_sched: XOR engine model, operand buffer
// model, directed jobs with hand-computed expected result words.
module tb_me_job_sched;

    localparam int K  = 16;
    localparam int N  = 8;
    localparam int SG = 3;
    localparam int TO = 100;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          op_rd_en;
    logic [IW-1:0] op_rd_idx;
    logic [K-1:0]  op_x, op_y;
    logic          me_start;
    logic [K-1:0]  me_x, me_y;
    logic          me_x_valid, me_y_valid;
    logic [K-1:0]  me_result;
    logic          me_valid;
    logic [K-1:0]  res_data;
    logic          res_valid;
    logic [IW-1:0] res_idx;
    logic          res_sel;
    logic          job_done, job_err;

    me_job_sched #(.K(K), .N(N), .START_GAP(SG), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
        .op_rd_en(op_rd_en), .op_rd_idx(op_rd_idx),
        .op_x(op_x), .op_y(op_y), .me_start(me_start),
        .me_x(me_x), .me_x_valid(me_x_valid),
        .me_y(me_y), .me_y_valid(me_y_valid),
        .me_result(me_result), .me_valid(me_valid),
        .res_data(res_data), .res_valid(res_valid), .res_idx(res_idx),
        .res_sel(res_sel), .job_done(job_done), .job_err(job_err)
    );

    always #5 clk = ~clk;

    // Operand tables and hand-computed XOR results
    logic [K-1:0] x0 [N] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008,
                             16'h0010, 16'h0020, 16'h0040, 16'h0080};
    logic [K-1:0] y0 [N] = '{16'h0100, 16'h0200, 16'h0400, 16'h0800,
                             16'h1000, 16'h2000, 16'h4000, 16'h8000};
    logic [K-1:0] e0 [N] = '{16'h0101, 16'h0202, 16'h0404, 16'h0808,
                             16'h1010, 16'h2020, 16'h4040, 16'h8080};
    logic [K-1:0] x1 [N] = '{16'hFFFF, 16'h0000, 16'hAAAA, 16'h5555,
                             16'h1234, 16'h0F0F, 16'hF0F0, 16'h8001};
    logic [K-1:0] y1 [N] = '{16'h0000, 16'hFFFF, 16'h5555, 16'h5555,
                             16'h4321, 16'h0F0F, 16'h0F0F, 16'h0001};
    logic [K-1:0] e1 [N] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000,
                             16'h5115, 16'h0000, 16'hFFFF, 16'h8000};

    typedef struct {
        int           idx;
        logic [K-1:0] data;
        logic         sel;
    } res_t;

    typedef struct {
        logic sel;
        logic err;
    } done_t;

    res_t  rq[$];
    done_t dq[$];

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int pad_cyc = 0;
    int mode   = 0;
    bit stray_en = 0;
    bit tmo_chk  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Operand buffer: data appears one cycle after the read strobe
    initial begin
        logic [K-1:0] px, py;
        px = '0;
        py = '0;
        op_x = '0;
        op_y = '0;
        forever begin
            @(negedge clk);
            op_x = px;
            op_y = py;
            if (op_rd_en) begin
                px = gnt[1] ? x1[op_rd_idx] : x0[op_rd_idx];
                py = gnt[1] ? y1[op_rd_idx] : y0[op_rd_idx];
            end else begin
                px = '0;
                py = '0;
            end
        end
    end

    // Engine model: result word i = x[i] ^ y[i]
    initial begin
        logic [K-1:0] rx [0:N];
        logic [K-1:0] last;
        int nrun, lat, ek, stray, lim;
        bit resp;
        nrun = 0; lat = 0; ek = 0; stray = 0; resp = 0; last = '0;
        me_valid = 1'b0;
        me_result = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                nrun = 0; resp = 0; ek = 0; stray = 0;
                me_valid = 1'b0;
                me_result = '0;
            end else begin
                if (me_start && stray_en) stray = 13;
                if (me_x_valid) begin
                    if (nrun <= N) rx[nrun] = me_x ^ me_y;
                    last = me_x | me_y;
                    nrun++;
                    if (nrun == N + 1) pad_cyc = cyc;
                end else if (nrun > 0) begin
                    checks++;
                    if (nrun != N + 1) begin
                        errs++;
                        $display("FAIL stream_len got=%0d want=%0d", nrun, N + 1);
                    end
                    checks++;
                    if (last != '0) begin
                        errs++;
                        $display("FAIL pad_word got=%h want=0", last);
                    end
                    nrun = 0;
                    if (mode != 1) begin
                        resp = 1; lat = 3; ek = 0;
                    end
                end
                lim = (mode == 2) ? 5 : N;
                me_valid = 1'b0;
                me_result = '0;
                if (resp) begin
                    if (lat > 0) begin
                        lat--;
                    end else if (ek < lim) begin
                        me_valid = 1'b1;
                        me_result = rx[ek];
                        ek++;
                    end else begin
                        resp = 0;
                    end
                end else if (stray > 0) begin
                    me_valid = stray[0];
                    me_result = 16'hDEAD;
                    stray--;
                end
            end
        end
    end

    // Monitor: pops scoreboard whenever the DUT presents an output
    initial begin
        res_t  r;
        done_t d;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checks++;
                if (gnt == 2'b11 || me_y_valid != me_x_valid ||
                    (!me_x_valid && (me_x != '0 || me_y != '0))) begin
                    errs++;
                    $display("FAIL protocol gnt=%b xv=%b yv=%b x=%h y=%h",
                             gnt, me_x_valid, me_y_valid, me_x, me_y);
                end
                if (res_valid) begin
                    checks++;
                    if (rq.size() == 0) begin
                        errs++;
                        $display("FAIL res_unexpected idx=%0d data=%h", res_idx, res_data);
                    end else begin
                        r = rq.pop_front();
                        if (int'(res_idx) != r.idx || res_data != r.data || res_sel != r.sel) begin
                            errs++;
                            $display("FAIL res_word got idx=%0d data=%h sel=%0d want idx=%0d data=%h sel=%0d",
                                     res_idx, res_data, res_sel, r.idx, r.data, r.sel);
                        end
                    end
                end
                if (job_done) begin
                    checks++;
                    if (dq.size() == 0) begin
                        errs++;
                        $display("FAIL done_unexpected sel=%0d err=%0d", res_sel, job_err);
                    end else begin
                        d = dq.pop_front();
                        if (res_sel != d.sel || job_err != d.err) begin
                            errs++;
                            $display("FAIL job_done got sel=%0d err=%0d want sel=%0d err=%0d",
                                     res_sel, job_err, d.sel, d.err);
                        end
                    end
                    if (tmo_chk) begin
                        checks++;
                        if (cyc - pad_cyc != TO) begin
                            errs++;
                            $display("FAIL timeout_cycles got=%0d want=%0d", cyc - pad_cyc, TO);
                        end
                    end
                end
            end
        end
    end

    task automatic push_job(input bit sel, input int nw, input bit err);
        res_t  r;
        done_t d;
        for (int i = 0; i < nw; i++) begin
            r.idx  = i;
            r.data = sel ? e1[i] : e0[i];
            r.sel  = sel;
            rq.push_back(r);
        end
        d.sel = sel;
        d.err = err;
        dq.push_back(d);
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (job_done) begin
                seen = 1;
                req[res_sel] = 1'b0;
            end
        end
        if (!seen) begin
            checks++;
            errs++;
            $display("FAIL done_wait got=none want=job_done within %0d cycles", budget);
            req = 2'b00;
        end
    endtask

    task automatic chk_zero(input string name);
        logic [127:0] v;
        v = {gnt, op_rd_en, op_rd_idx, me_start, me_x, me_x_valid, me_y,
             me_y_valid, res_data, res_valid, res_idx, res_sel, job_done, job_err};
        checks++;
        if (v != '0) begin
            errs++;
            $display("FAIL %s outputs got=%h want=0", name, v);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit hit;
        rst_n = 1'b0;
        req = 2'b00;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // single job for requester 0
        push_job(0, N, 0);
        req = 2'b01;
        wait_done(100);
        repeat (2) @(negedge clk);

        // both requesting from reset: 0 then 1
        do_reset();
        push_job(0, N, 0);
        push_job(1, N, 0);
        req = 2'b11;
        wait_done(100);
        wait_done(100);
        repeat (2) @(negedge clk);

        // engine silent: timeout abort
        mode = 1;
        tmo_chk = 1;
        push_job(0, 0, 1);
        req = 2'b01;
        wait_done(250);
        repeat (2) @(negedge clk);
        tmo_chk = 0;

        // engine drops after 5 words
        mode = 2;
        push_job(1, 5, 1);
        req = 2'b10;
        wait_done(100);
        repeat (2) @(negedge clk);

        // reset during streaming, then requester 1 job
        mode = 0;
        req = 2'b01;
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (op_rd_en && op_rd_idx == IW'(5)) hit = 1;
        end
        checks++;
        if (!hit) begin
            errs++;
            $display("FAIL stream_reach got=none want=op_rd_idx 5");
        end
        rst_n = 1'b0;
        req = 2'b00;
        #1;
        chk_zero("async_reset");
        @(negedge clk);
        chk_zero("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        push_job(1, N, 0);
        req = 2'b10;
        wait_done(100);
        repeat (2) @(negedge clk);

        // stray engine valids during gap and stream
        stray_en = 1;
        push_job(0, N, 0);
        req = 2'b01;
        wait_done(100);
        stray_en = 0;
        repeat (4) @(negedge clk);

        checks++;
        if (rq.size() != 0) begin
            errs++;
            $display("FAIL res_left got=%0d want=0", rq.size());
        end
        checks++;
        if (dq.size() != 0) begin
            errs++;
            $display("FAIL done_left got=%0d want=0", dq.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
